// File: rtl/motor_pulse_decoder.sv
// Motor pulse decoder: edge-detects 2-bit command pulses into fwd/rev drive enables, with a dead band on reversal.
// Latency: fwd/rev change on the edge that accepts a command, one cycle after `in` changes.
// Backpressure: none; a command during DEAD only retargets the pending direction. Optional err flag: MOTOR_DECODE_ERR_EN.
module motor_pulse_decoder #(
    parameter int DEAD_CYCLES = 4,
    parameter int RUN_CYCLES  = 200
) (
    input  logic       orgclk,
    input  logic       rst_n,
    input  logic [1:0] in,
    output logic       fwd,
    output logic       rev,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;

    localparam logic [15:0] RUN_LOAD  = 16'(RUN_CYCLES - 1);
    localparam logic [7:0]  DEAD_LOAD = 8'(DEAD_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] run_cnt, run_cnt_nxt;
    logic [7:0]  dead_cnt, dead_cnt_nxt;
    logic        pend_rev, pend_rev_nxt;
    logic [1:0]  prev_in;
    logic        armed;
    logic        acc_fwd, acc_rev;

    // armed stays low after reset until `in` is seen idle, so a pulse held across reset is ignored
    assign acc_fwd = armed && (prev_in == 2'b00) && (in == 2'b01);
    assign acc_rev = armed && (prev_in == 2'b00) && (in == 2'b10);
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        run_cnt_nxt  = run_cnt;
        dead_cnt_nxt = dead_cnt;
        pend_rev_nxt = pend_rev;
        case (state)
            IDLE: begin
                if (acc_fwd) begin
                    state_nxt   = FWD;
                    run_cnt_nxt = RUN_LOAD;
                end else if (acc_rev) begin
                    state_nxt   = REV;
                    run_cnt_nxt = RUN_LOAD;
                end
            end
            FWD: begin
                if (acc_fwd) begin
                    run_cnt_nxt = RUN_LOAD;
                end else if (acc_rev) begin
                    state_nxt    = DEAD;
                    dead_cnt_nxt = DEAD_LOAD;
                    pend_rev_nxt = 1'b1;
                end else if (run_cnt == 16'd0) begin
                    state_nxt = IDLE;
                end else begin
                    run_cnt_nxt = run_cnt - 16'd1;
                end
            end
            REV: begin
                if (acc_rev) begin
                    run_cnt_nxt = RUN_LOAD;
                end else if (acc_fwd) begin
                    state_nxt    = DEAD;
                    dead_cnt_nxt = DEAD_LOAD;
                    pend_rev_nxt = 1'b0;
                end else if (run_cnt == 16'd0) begin
                    state_nxt = IDLE;
                end else begin
                    run_cnt_nxt = run_cnt - 16'd1;
                end
            end
            DEAD: begin
                if (acc_fwd) begin
                    pend_rev_nxt = 1'b0;
                end else if (acc_rev) begin
                    pend_rev_nxt = 1'b1;
                end
                // a command landing on the final dead cycle still picks the direction taken
                if (dead_cnt == 8'd0) begin
                    state_nxt   = pend_rev_nxt ? REV : FWD;
                    run_cnt_nxt = RUN_LOAD;
                end else begin
                    dead_cnt_nxt = dead_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge orgclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            run_cnt  <= 16'd0;
            dead_cnt <= 8'd0;
            pend_rev <= 1'b0;
            prev_in  <= 2'b00;
            armed    <= 1'b0;
            fwd      <= 1'b0;
            rev      <= 1'b0;
        end else begin
            state    <= state_nxt;
            run_cnt  <= run_cnt_nxt;
            dead_cnt <= dead_cnt_nxt;
            pend_rev <= pend_rev_nxt;
            prev_in  <= in;
            armed    <= armed | (in == 2'b00);
            fwd      <= (state_nxt == FWD);
            rev      <= (state_nxt == REV);
        end
    end

`ifdef MOTOR_DECODE_ERR_EN
    always_ff @(posedge orgclk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (armed && (prev_in == 2'b00) && (in == 2'b11)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_motor_pulse_decoder.sv
// Bench for motor_pulse_decoder: timestamp-based drive model checked every cycle, plus directed literal checks.
module tb_motor_pulse_decoder;

    localparam int RUN  = 200;
    localparam int DEAD = 4;
`ifdef MOTOR_DECODE_ERR_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_FWD  = 1;
    localparam int M_REV  = 2;
    localparam int M_DEAD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in;
    logic       fwd, rev, busy, err;

    int checks = 0;
    int failures = 0;

    motor_pulse_decoder #(.DEAD_CYCLES(DEAD), .RUN_CYCLES(RUN)) dut (
        .orgclk (clk),
        .rst_n  (rst_n),
        .in     (in),
        .fwd    (fwd),
        .rev    (rev),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: drive modes with absolute cycle deadlines instead of countdown registers.
    int       n = 0;
    int       mode = M_IDLE;
    int       off_at = 0;
    int       dead_end = 0;
    int       pend = M_FWD;
    int       cmd;
    logic [1:0] m_prev = 2'b00;
    bit       m_armed = 1'b0;
    bit       m_err = 1'b0;
    bit       started = 1'b0;

    always @(posedge clk) begin
        n++;
        if (!rst_n) begin
            mode    = M_IDLE;
            pend    = M_FWD;
            m_prev  = 2'b00;
            m_armed = 1'b0;
            m_err   = 1'b0;
        end else begin
            cmd = M_IDLE;
            if (m_armed && m_prev == 2'b00 && in == 2'b01) cmd = M_FWD;
            if (m_armed && m_prev == 2'b00 && in == 2'b10) cmd = M_REV;
            if (ERR_EN != 0 && m_armed && m_prev == 2'b00 && in == 2'b11) m_err = 1'b1;
            if (mode == M_IDLE) begin
                if (cmd != M_IDLE) begin
                    mode   = cmd;
                    off_at = n + RUN;
                end
            end else if (mode == M_DEAD) begin
                if (cmd != M_IDLE) pend = cmd;
                if (n >= dead_end) begin
                    mode   = pend;
                    off_at = n + RUN;
                end
            end else begin
                if (cmd == mode) begin
                    off_at = n + RUN;
                end else if (cmd != M_IDLE) begin
                    mode     = M_DEAD;
                    dead_end = n + DEAD;
                    pend     = cmd;
                end else if (n >= off_at) begin
                    mode = M_IDLE;
                end
            end
            m_prev = in;
            if (in == 2'b00) m_armed = 1'b1;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_fwd",  int'(fwd),  int'(mode == M_FWD));
            chk("model_rev",  int'(rev),  int'(mode == M_REV));
            chk("model_busy", int'(busy), int'(mode != M_IDLE));
            chk("model_err",  int'(err),  int'(m_err));
            chk("fwd_rev_excl", int'(fwd & rev), 0);
        end
    end

    task automatic step(input logic [1:0] v, input int cycles);
        in = v;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    int lows;

    initial begin
        rst_n = 1'b0;
        in    = 2'b00;
        step(2'b00, 2);
        chk("rst_fwd", int'(fwd), 0);
        chk("rst_rev", int'(rev), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        step(2'b00, 2);

        // single forward pulse runs exactly RUN cycles
        step(2'b01, 1);
        chk("a_fwd_first_edge", int'(fwd), 1);
        chk("a_busy", int'(busy), 1);
        step(2'b01, 2);
        step(2'b00, 197);
        chk("a_fwd_last_cycle", int'(fwd), 1);
        step(2'b00, 1);
        chk("a_fwd_expired", int'(fwd), 0);
        chk("a_idle", int'(busy), 0);

        // reversal passes through DEAD_CYCLES of both-off
        step(2'b01, 1);
        chk("b_fwd", int'(fwd), 1);
        step(2'b00, 5);
        step(2'b10, 1);
        chk("b_dead_fwd", int'(fwd), 0);
        chk("b_dead_rev", int'(rev), 0);
        chk("b_dead_busy", int'(busy), 1);
        step(2'b10, 1);
        step(2'b00, 2);
        chk("b_dead_last", int'(rev), 0);
        step(2'b00, 1);
        chk("b_rev_on", int'(rev), 1);
        chk("b_fwd_off", int'(fwd), 0);

        // back to forward, then overwrite pending mid-dead
        step(2'b01, 1);
        step(2'b00, 3);
        chk("c_dead_hold", int'(fwd), 0);
        step(2'b00, 1);
        chk("c_fwd_on", int'(fwd), 1);
        step(2'b10, 1);
        step(2'b00, 1);
        step(2'b01, 1);
        step(2'b00, 1);
        chk("c_dead_not_restarted_busy", int'(busy), 1);
        chk("c_dead_not_restarted_fwd", int'(fwd), 0);
        step(2'b00, 1);
        chk("c_pending_fwd", int'(fwd), 1);
        chk("c_rev_off", int'(rev), 0);

        // periodic refresh keeps forward on continuously
        lows = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 150; j++) begin
                step((j == 149) ? 2'b01 : 2'b00, 1);
                if (!fwd) lows++;
            end
        end
        chk("d_fwd_low_cycles", lows, 0);

        // illegal code
        step(2'b00, 1);
        step(2'b11, 1);
        chk("e_err", int'(err), ERR_EN);
        chk("e_fwd_kept", int'(fwd), 1);
        step(2'b00, 3);
        chk("e_err_sticky", int'(err), ERR_EN);

        // reset mid-dead with pulse held
        step(2'b10, 1);
        chk("f_dead_busy", int'(busy), 1);
        chk("f_dead_fwd", int'(fwd), 0);
        step(2'b10, 1);
        rst_n = 1'b0;
        step(2'b10, 1);
        chk("f_rst_busy", int'(busy), 0);
        chk("f_rst_fwd", int'(fwd), 0);
        chk("f_rst_rev", int'(rev), 0);
        chk("f_rst_err", int'(err), 0);
        rst_n = 1'b1;
        step(2'b10, 3);
        chk("f_held_ignored", int'(busy), 0);
        chk("f_held_rev", int'(rev), 0);
        step(2'b00, 1);
        step(2'b10, 1);
        chk("f_rearmed_rev", int'(rev), 1);
        step(2'b00, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/motor_pulse_decoder.md
MOTOR_PULSE_DECODER -- requirements
Module: motor_pulse_decoder

Interface
REQ-001 Parameter: DEAD_CYCLES, default 4; orgclk cycles with both drives off on a direction reversal (legal range 1..255).
REQ-002 Parameter: RUN_CYCLES, default 200; orgclk cycles the drive stays on after the last accepted command (legal range 1..65535).
REQ-003 Port: orgclk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of orgclk.
REQ-005 Port: in  input  2  pulse code from the motor command encoder; 00 idle, 01 forward, 10 reverse, 11 illegal.
REQ-006 Port: fwd  output  1  forward drive enable, registered.
REQ-007 Port: rev  output  1  reverse drive enable, registered.
REQ-008 Port: busy  output  1  high in any state other than IDLE.
REQ-009 Port: err  output  1  sticky illegal-code flag (see Configuration).

Function
REQ-010 The block SHALL treat an input pulse as one command, however many orgclk cycles it lasts.
REQ-011 A command SHALL be accepted only in a cycle where `in` is 01 or 10 and the registered previous value of `in` was 00.
REQ-012 The block SHALL implement a four-state FSM: IDLE, FWD, REV, DEAD.
REQ-013 IDLE: fwd=0, rev=0; an accepted 01 SHALL go to FWD and an accepted 10 SHALL go to REV, each loading the run counter with RUN_CYCLES-1.
REQ-014 FWD: fwd=1, rev=0; an accepted 01 SHALL reload the run counter and stay in FWD.
REQ-015 FWD: an accepted 10 SHALL go to DEAD, load the dead counter with DEAD_CYCLES-1, and latch pending direction = reverse.
REQ-016 REV SHALL behave as the mirror image of FWD (01 and 10 swapped, fwd and rev swapped).
REQ-017 FWD/REV: when the run counter reaches 0 and no command is accepted in that cycle, the FSM SHALL go to IDLE.
REQ-018 FWD/REV: the run counter SHALL otherwise decrement by 1 per cycle and saturate at 0, never wrapping.
REQ-019 DEAD: fwd=0, rev=0; the dead counter SHALL decrement by 1 per cycle.
REQ-020 DEAD: at dead count 0 the FSM SHALL enter the pending direction with the run counter loaded to RUN_CYCLES-1.
REQ-021 DEAD: an accepted command SHALL overwrite the pending direction without restarting the dead counter.
REQ-022 fwd and rev SHALL never both be 1 in any cycle, and a direction change SHALL always pass through DEAD for exactly DEAD_CYCLES cycles.
REQ-023 Output latency: fwd/rev SHALL change on the clock edge that accepts the command, i.e. one cycle after `in` changes.
REQ-024 Run counter width SHALL be 16 bits; dead counter width SHALL be 8 bits.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, fwd=0, rev=0, busy=0, err=0, both counters to 0, the previous-`in` register to 00, and the pending direction to forward.
REQ-026 Reset asserted in any state, including mid-DEAD, SHALL take effect at the next edge with no extra drive cycle.
REQ-027 After rst_n deasserts, a pulse already at 01/10 SHALL NOT be accepted until `in` has returned to 00.

Configuration
REQ-028 With MOTOR_DECODE_ERR_EN defined, a 00->11 transition on `in` SHALL set err=1; err SHALL stay 1 until reset, and the FSM SHALL be unaffected.
REQ-029 Without MOTOR_DECODE_ERR_EN, the code 11 SHALL be ignored and err SHALL be tied to 0.

Verification
REQ-030 Reset, then in=01 for 3 cycles, then 00 -> fwd=1 from the first edge, held for 200 cycles, then IDLE and busy=0.
REQ-031 In FWD, in=10 pulse -> fwd=0 for exactly 4 cycles with rev=0, then rev=1; fwd&rev never 1.
REQ-032 In FWD, repeat the 01 pulse every 150 cycles -> fwd stays 1 continuously and no IDLE visit occurs.
REQ-033 In DEAD after 10, apply 01 at dead count 2 -> DEAD still lasts 4 cycles total, then fwd=1.
REQ-034 With MOTOR_DECODE_ERR_EN, 00->11 -> err=1 sticky, fwd/rev unchanged; without the macro -> err=0.
REQ-035 rst_n=0 mid-DEAD with in held at 10 -> IDLE next edge; no command accepted until in returns to 00.
